// File: rtl/gost_pkg.sv
// Shared definitions for the Magma (GOST R 34.12-2015) block cipher datapaths.
//   state_e    : control FSM states of the iterative cores
//   PI         : Magma S-box, PI[i][v] substitutes nibble i holding value v
//   BLOCK_W    : cipher block width (64)
//   KEY_W      : key width (256)
//   ROUNDS     : Feistel round count (32)
//   key_idx()  : round-key index for decryption round r
package gost_pkg;

  localparam int unsigned BLOCK_W = 64;
  localparam int unsigned KEY_W   = 256;
  localparam int unsigned ROUNDS  = 32;

  localparam logic [4:0] LastRound = 5'(ROUNDS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [3:0] PI [0:7][0:15] = '{
    '{4'hc, 4'h4, 4'h6, 4'h2, 4'ha, 4'h5, 4'hb, 4'h9,
      4'he, 4'h8, 4'hd, 4'h7, 4'h0, 4'h3, 4'hf, 4'h1},
    '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'ha, 4'h5, 4'hc,
      4'h1, 4'he, 4'h4, 4'h7, 4'hb, 4'hd, 4'h0, 4'hf},
    '{4'hb, 4'h3, 4'h5, 4'h8, 4'h2, 4'hf, 4'ha, 4'hd,
      4'he, 4'h1, 4'h7, 4'h4, 4'hc, 4'h9, 4'h6, 4'h0},
    '{4'hc, 4'h8, 4'h2, 4'h1, 4'hd, 4'h4, 4'hf, 4'h6,
      4'h7, 4'h0, 4'ha, 4'h5, 4'h3, 4'he, 4'h9, 4'hb},
    '{4'h7, 4'hf, 4'h5, 4'ha, 4'h8, 4'h1, 4'h6, 4'hd,
      4'h0, 4'h9, 4'h3, 4'he, 4'hb, 4'h4, 4'h2, 4'hc},
    '{4'h5, 4'hd, 4'hf, 4'h6, 4'h9, 4'h2, 4'hc, 4'ha,
      4'hb, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'he, 4'h0},
    '{4'h8, 4'he, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hc,
      4'hf, 4'h4, 4'hb, 4'h0, 4'hd, 4'ha, 4'h3, 4'h7},
    '{4'h1, 4'h7, 4'he, 4'hd, 4'h0, 4'h5, 4'h8, 4'h3,
      4'h4, 4'hf, 4'ha, 4'h6, 4'h9, 4'hc, 4'hb, 4'h2}
  };

  // Decryption schedule: K1..K8 once, then K8..K1 three times (0-based index).
  function automatic logic [2:0] key_idx(input logic [4:0] r);
    return (r < 5'd8) ? r[2:0] : (3'd7 - r[2:0]);
  endfunction

endpackage

// File: rtl/magma_g.sv
// Magma round function g(x, k) = ROL11(S(x + k mod 2^32)).
// Purely combinational.
//   x_i : 32-bit half-block
//   k_i : 32-bit round key
//   y_o : 32-bit result
module magma_g
  import gost_pkg::*;
(
  input  logic [31:0] x_i,
  input  logic [31:0] k_i,
  output logic [31:0] y_o
);

  logic [31:0] sum;
  logic [31:0] sub;

  always_comb begin
    sum = x_i + k_i;
    sub = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      sub[4*i +: 4] = PI[i][sum[4*i +: 4]];
    end
    y_o = {sub[20:0], sub[31:21]};
  end

endmodule

// File: rtl/gost_decrypt_iter.sv
// Iterative Magma block decryptor, one Feistel round per clock.
// Accepts a ciphertext on the AXI-Stream slave, runs 32 rounds with the
// decryption key schedule and holds the plaintext on the AXI-Stream master.
//   clk, rst_n       : clock, asynchronous active-low reset
//   key              : 256-bit key, K1 = key[255:224] .. K8 = key[31:0]
//   s_axis_*         : ciphertext input stream (tdata[63:32] = a1)
//   m_axis_*         : plaintext output stream
module gost_decrypt_iter
  import gost_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_W-1:0]   key,
  input  logic [BLOCK_W-1:0] s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [BLOCK_W-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready
);

  state_e             state_q, state_d;
  logic [4:0]         r_q, r_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [BLOCK_W-1:0] tdata_q, tdata_d;
  logic               tvalid_q, tvalid_d;

  logic [2:0]  k_idx;
  logic [31:0] round_key;
  logic [31:0] g_out;
  logic [31:0] feistel;
  logic        in_xfer;

  // K1 sits in the top word, so index i selects word (7 - i).
  always_comb begin
    k_idx     = key_idx(r_q);
    round_key = key_q[{3'd7 - k_idx, 5'd0} +: 32];
  end

  magma_g u_magma_g (
    .x_i (lo_q),
    .k_i (round_key),
    .y_o (g_out)
  );

  assign feistel = g_out ^ hi_q;

  // Ready in DONE only when the held result leaves this cycle, giving the
  // overlapped accept that keeps back-to-back blocks 33 cycles apart.
  assign s_axis_tready = (state_q == StIdle) || ((state_q == StDone) && m_axis_tready);
  assign in_xfer       = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    key_d    = key_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;

    unique case (state_q)
      StIdle: begin
        if (in_xfer) begin
          hi_d    = s_axis_tdata[63:32];
          lo_d    = s_axis_tdata[31:0];
          key_d   = key;
          r_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (r_q == LastRound) begin
          // Final round has no half swap.
          tdata_d  = {feistel, lo_q};
          tvalid_d = 1'b1;
          state_d  = StDone;
        end else begin
          hi_d = lo_q;
          lo_d = feistel;
          r_d  = r_q + 5'd1;
        end
      end
      StDone: begin
        if (m_axis_tready) begin
          tvalid_d = 1'b0;
          state_d  = StIdle;
          if (s_axis_tvalid) begin
            hi_d    = s_axis_tdata[63:32];
            lo_d    = s_axis_tdata[31:0];
            key_d   = key;
            r_d     = '0;
            state_d = StRun;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      r_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      key_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      key_q    <= key_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_gost_decrypt_iter.sv
module tb_gost_decrypt_iter;

  logic         clk;
  logic         rst_n;
  logic [255:0] key;
  logic [63:0]  s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [63:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [255:0] StdKey =
    256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0] StdCt = 64'h4ee901e5c2d8ca3d;
  localparam logic [63:0] StdPt = 64'hfedcba9876543210;

  // Reference S-box rows, entry 0 in the most significant nibble.
  localparam logic [63:0] SboxRows [8] = '{
    64'hc462a5b9e8d703f1, 64'h68239a5c1e47bd0f, 64'hb3582fade174c960, 64'hc821d4f670a53e9b,
    64'h7f5a816d093eb42c, 64'h5df692cab78143e0, 64'h8e25691cf4b0da37, 64'h17ed05834fa69cb2
  };

  gost_decrypt_iter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key           (key),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_g(input logic [31:0] a, input logic [31:0] k);
    logic [31:0] s;
    logic [31:0] t;
    logic [63:0] row;
    int          nib;
    s = a + k;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      row = SboxRows[i];
      nib = int'(s[4*i +: 4]);
      t[4*i +: 4] = row[(15 - nib)*4 +: 4];
    end
    return {t[20:0], t[31:21]};
  endfunction

  // Golden encryptor: K1..K8 three times, then K8..K1, last round unswapped.
  function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [255:0] k);
    logic [31:0] a1;
    logic [31:0] a0;
    logic [31:0] t;
    logic [31:0] rk;
    int          ki;
    a1 = pt[63:32];
    a0 = pt[31:0];
    for (int j = 0; j < 32; j++) begin
      ki = (j < 24) ? (j % 8) : (7 - (j % 8));
      rk = k[255 - 32*ki -: 32];
      t  = ref_g(a0, rk) ^ a1;
      if (j < 31) begin
        a1 = a0;
        a0 = t;
      end else begin
        a1 = t;
      end
    end
    return {a1, a0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one block and return right after its accept edge.
  task automatic send(input logic [63:0] ct, input logic [255:0] k);
    int guard;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = ct;
    key           = k;
    guard = 0;
    while (!s_axis_tready && guard < 100) begin
      tick();
      guard++;
    end
    check("send_ready", {63'd0, s_axis_tready}, 64'd1);
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!m_axis_tvalid && lat < 60) begin
      tick();
      lat++;
    end
    check("out_seen", {63'd0, m_axis_tvalid}, 64'd1);
  endtask

  task automatic release_out();
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [63:0] held;
    logic [63:0] bb_pt [4];
    logic [63:0] bb_ct [4];
    int          nacc, nout, cyc, last_out, n_rdy;
    logic        acc, out;
    logic [255:0] rk;
    logic [63:0]  rp;

    rst_n         = 1'b0;
    key           = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    #1;
    check("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_sready", {63'd0, s_axis_tready}, 64'd1);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Standard vector and latency.
    send(StdCt, StdKey);
    wait_out(lat);
    check("latency", 64'(lat), 64'd32);
    check("std_data", m_axis_tdata, StdPt);

    // Backpressure: output held, no accept.
    held = m_axis_tdata;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 64'h0123456789abcdef;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_data", m_axis_tdata, held);
      check("bp_valid", {63'd0, m_axis_tvalid}, 64'd1);
      check("bp_sready", {63'd0, s_axis_tready}, 64'd0);
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    #1;
    check("bp_sready_done", {63'd0, s_axis_tready}, 64'd1);
    tick();
    m_axis_tready = 1'b0;
    #1;
    check("bp_valid_drop", {63'd0, m_axis_tvalid}, 64'd0);
    check("bp_idle_sready", {63'd0, s_axis_tready}, 64'd1);

    // Key change during RUN has no effect.
    send(StdCt, StdKey);
    repeat (5) tick();
    key = '0;
    wait_out(lat);
    check("keychg_data", m_axis_tdata, StdPt);
    release_out();

    // Reset in the middle of a block.
    send(StdCt, StdKey);
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("midrst_tdata", m_axis_tdata, 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("midrst_no_out", {63'd0, m_axis_tvalid}, 64'd0);
    send(StdCt, StdKey);
    wait_out(lat);
    check("postrst_lat", 64'(lat), 64'd32);
    check("postrst_data", m_axis_tdata, StdPt);
    release_out();

    // Back-to-back blocks with both sides always ready.
    for (int i = 0; i < 4; i++) begin
      bb_pt[i] = {$urandom, $urandom};
      bb_ct[i] = ref_encrypt(bb_pt[i], StdKey);
    end
    key           = StdKey;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = bb_ct[0];
    nacc = 0; nout = 0; cyc = 0; last_out = 0; n_rdy = 0;
    #1;
    for (int i = 0; i < 300 && nout < 4; i++) begin
      acc = s_axis_tvalid && s_axis_tready;
      out = m_axis_tvalid && m_axis_tready;
      if (nacc > 0 && s_axis_tready) n_rdy++;
      if (out) begin
        check("b2b_data", m_axis_tdata, bb_pt[nout]);
        if (nout > 0) check("b2b_gap", 64'(cyc - last_out), 64'd33);
        last_out = cyc;
        nout++;
      end
      tick();
      cyc++;
      if (acc) begin
        nacc++;
        if (nacc < 4) s_axis_tdata = bb_ct[nacc];
        else s_axis_tvalid = 1'b0;
      end
    end
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b0;
    check("b2b_count", 64'(nout), 64'd4);
    check("b2b_sready_pulses", 64'(n_rdy), 64'd4);

    // Round trip with random keys and plaintexts.
    for (int i = 0; i < 100; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom};
      send(ref_encrypt(rp, rk), rk);
      wait_out(lat);
      check("roundtrip", m_axis_tdata, rp);
      release_out();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gost_decrypt_iter.md
# gost_decrypt_iter

Iterative GOST R 34.12-2015 (Magma) block decryptor: accepts one 64-bit ciphertext block per AXI-Stream transfer, runs the 32 Feistel rounds with the reversed key schedule at one round per clock, and presents the 64-bit plaintext on an AXI-Stream master. It is the receive-side counterpart of the pipelined encryptor: it trades throughput for area (one round datapath instead of a pipeline) and is used where block rate is low.

## Interface
- No parameters (block width 64, key width 256 and round count 32 are fixed by the cipher and defined in the package).
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key  in  256  decryption key; K1 = key[255:224] ... K8 = key[31:0]; sampled only on an input transfer.
- s_axis_tdata  in  64  ciphertext block; high half a1 = [63:32], low half a0 = [31:0].
- s_axis_tvalid  in  1  ciphertext valid.
- s_axis_tready  out  1  block can accept a ciphertext this cycle.
- m_axis_tdata  out  64  plaintext block.
- m_axis_tvalid  out  1  plaintext valid.
- m_axis_tready  in  1  downstream accepts plaintext.

## Operation
- State machine with states IDLE, RUN and DONE; reset state is IDLE.
- s_axis_tready = (state == IDLE) || (state == DONE && m_axis_tready). It is combinational and never depends on s_axis_tvalid.
- Input transfer (s_axis_tvalid && s_axis_tready):
  - latch hi <= tdata[63:32], lo <= tdata[31:0] and the full key;
  - round counter r <= 0; state <= RUN.
- RUN, round r with round key Kidx:
  - idx = r for r < 8; idx = 7 - (r mod 8) for r >= 8.
  - This gives the order K1..K8, then K8..K1 three times.
- g(x,k) = ROL11(S(x + k mod 2^32)). S replaces nibble i (bits 4i+3:4i) with pi_i[nibble], for i = 0..7.
- Rounds r = 0..30: hi <= lo; lo <= g(lo,K) ^ hi.
- Round 31 (no swap): m_axis_tdata <= {g(lo,K) ^ hi, lo}; m_axis_tvalid <= 1; state <= DONE.
- DONE:
  - m_axis_tdata and m_axis_tvalid hold until m_axis_tready.
  - On m_axis_tready: m_axis_tvalid <= 0 and state <= IDLE.
  - If s_axis_tvalid is also high in that cycle, the new block is accepted in the same cycle and state <= RUN.
- The latched key is used for the whole block. Changes on key during RUN or DONE have no effect.
- Reset mid-operation: the block in flight is discarded. There is no partial output and m_axis_tvalid stays 0.

## Timing
- Reset values:
  - state IDLE; r = 0; hi and lo 0;
  - m_axis_tdata = 0; m_axis_tvalid = 0;
  - s_axis_tready = 1, as soon as state is IDLE.
- Inputs are ignored while rst_n is low.
- Latency: input transfer at edge t, then rounds 0..31 on edges t+1..t+32. m_axis_tvalid is high from edge t+32.
- Throughput with m_axis_tready held high: one block per 33 cycles, because of overlapped accept in DONE.
- m_axis_tvalid never drops without a transfer, and m_axis_tdata is stable while valid and not ready.
- Counter r is 5 bits and only counts in RUN. No wrap occurs, because the round 31 edge leaves RUN.

## Structure
- Package gost_pkg holds:
  - the state enum;
  - the Magma S-box constant pi[0:7][0:15] (4-bit entries, standard GOST R 34.12-2015 values);
  - localparams BLOCK_W = 64, KEY_W = 256, ROUNDS = 32.
- Sub-module magma_g: combinational g(x,k) with 32-bit in, 32-bit key and 32-bit out, shared with future encrypt variants.
- Top module: FSM, counter, key-index mux and output register.

## Test plan
- Standard vector: key = ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, s_axis_tdata = 4ee901e5c2d8ca3d -> m_axis_tdata = fedcba9876543210, with m_axis_tvalid rising exactly 32 cycles after the accept edge.
- Backpressure: m_axis_tready held low for 10 cycles after valid -> output is stable and s_axis_tready = 0. Then raise ready -> one transfer and the return to IDLE.
- Back-to-back traffic: s_axis_tvalid and m_axis_tready held high with 4 blocks -> 4 correct outputs spaced 33 cycles apart, and s_axis_tready pulses in each DONE cycle.
- Key change: key is changed to all-zero at cycle 5 of RUN -> output is still fedcba9876543210.
- Reset mid-RUN: rst_n pulsed low at round 15 -> m_axis_tvalid = 0 and m_axis_tdata = 0 immediately. The next block decrypts correctly.
- Round-trip: 100 random key/plaintext pairs are encrypted with the golden model and fed in -> every output equals its plaintext.
